// File: rtl/alu_share_arb.sv
// Two-requester arbiter in front of one shared combinational ALU. Each requester
// has a one-entry response slot with valid/ready handshakes on both sides.
module alu_share_arb #(
    parameter int               WIDTH      = 32,
    parameter int               OPW        = 5,
    parameter int               FIXED_PRIO = 0,
    parameter logic [OPW-1:0]   ALU_NOP    = OPW'(0),
    parameter logic [OPW-1:0]   ALU_ADD    = OPW'(1),
    parameter logic [OPW-1:0]   ALU_SUB    = OPW'(2)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [1:0]           req_valid,
    output logic [1:0]           req_ready,
    input  logic [2*OPW-1:0]     req_op,
    input  logic [2*WIDTH-1:0]   req_a,
    input  logic [2*WIDTH-1:0]   req_b,
    output logic [1:0]           rsp_valid,
    input  logic [1:0]           rsp_ready,
    output logic [2*WIDTH-1:0]   rsp_c,
    output logic [1:0]           rsp_zero,
    output logic [1:0]           rsp_ovf,
    output logic [1:0]           rsp_gez,
    output logic [WIDTH-1:0]     alu_a,
    output logic [WIDTH-1:0]     alu_b,
    output logic [OPW-1:0]       alu_op,
    input  logic [WIDTH-1:0]     alu_c,
    input  logic                 alu_zero,
    input  logic                 alu_ovf,
    input  logic                 alu_gez
);

    logic [1:0]       w_elig;
    logic [1:0]       w_grant;
    logic             w_ovf_m;
    logic             r_ptr;
    logic [1:0]       r_valid;
    logic [WIDTH-1:0] r_c    [2];
    logic [1:0]       r_zero;
    logic [1:0]       r_ovf;
    logic [1:0]       r_gez;

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_elig
            // A slot being drained this cycle can accept a new result on the same edge.
            assign w_elig[gi] = req_valid[gi] & (~r_valid[gi] | rsp_ready[gi]);
        end
    endgenerate

    always_comb begin
        w_grant = 2'b00;
        if (!rst) begin
            case (w_elig)
                2'b01:   w_grant = 2'b01;
                2'b10:   w_grant = 2'b10;
                2'b11:   w_grant = ((FIXED_PRIO != 0) || !r_ptr) ? 2'b01 : 2'b10;
                default: w_grant = 2'b00;
            endcase
        end
    end

    assign req_ready = w_grant;

    // Pointer names the requester favoured on the next tie; it only moves on ties.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_ptr <= 1'b0;
        end else if (w_elig == 2'b11) begin
            r_ptr <= w_grant[0];
        end
    end

    always_comb begin
        alu_a  = '0;
        alu_b  = '0;
        alu_op = ALU_NOP;
        if (w_grant[1]) begin
            alu_a  = req_a[WIDTH +: WIDTH];
            alu_b  = req_b[WIDTH +: WIDTH];
            alu_op = req_op[OPW +: OPW];
        end else if (w_grant[0]) begin
            alu_a  = req_a[0 +: WIDTH];
            alu_b  = req_b[0 +: WIDTH];
            alu_op = req_op[0 +: OPW];
        end
    end

    // The ALU overflow output is only meaningful for add/sub.
    assign w_ovf_m = alu_ovf & ((alu_op == ALU_ADD) | (alu_op == ALU_SUB));

    generate
        for (gi = 0; gi < 2; gi++) begin : g_slot
            always_ff @(posedge clk) begin
                if (rst) begin
                    r_valid[gi] <= 1'b0;
                    r_c[gi]     <= '0;
                    r_zero[gi]  <= 1'b0;
                    r_ovf[gi]   <= 1'b0;
                    r_gez[gi]   <= 1'b0;
                end else if (w_grant[gi]) begin
                    r_valid[gi] <= 1'b1;
                    r_c[gi]     <= alu_c;
                    r_zero[gi]  <= alu_zero;
                    r_ovf[gi]   <= w_ovf_m;
                    r_gez[gi]   <= alu_gez;
                end else if (rsp_ready[gi]) begin
                    r_valid[gi] <= 1'b0;
                end
            end

            assign rsp_c[gi*WIDTH +: WIDTH] = r_c[gi];
        end
    endgenerate

    assign rsp_valid = r_valid;
    assign rsp_zero  = r_zero;
    assign rsp_ovf   = r_ovf;
    assign rsp_gez   = r_gez;

endmodule
